// File: rtl/atm_session_timer.sv
// atm_session_timer: ATM session inactivity countdown driven by a 1 Hz square wave.
//   Optional macro SESSION_TIMER_BCD_EN adds registered BCD outputs rem_tens/rem_ones.
//   Ports:
//     clk       system clock (same clock as the seconds divider)
//     rst       asynchronous active-high reset
//     sec_in    1 Hz square wave, rising edge = one elapsed second
//     start     pulse, opens (or restarts) a session
//     kick      pulse, user activity, reloads a live countdown
//     stop      pulse, closes the session
//     remaining seconds left, 0 when not running
//     active    high in RUN or WARN
//     warning   high in WARN
//     timeout   one-cycle pulse on expiry
//     expired   high while in EXPIRED
//     rem_tens  BCD tens of remaining, clamped to 99 (macro only)
//     rem_ones  BCD ones of remaining, clamped to 99 (macro only)
module atm_session_timer #(
    parameter int TIMEOUT_SEC = 30,
    parameter int WARN_SEC    = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_in,
    input  logic             start,
    input  logic             kick,
    input  logic             stop,
    output logic [CNT_W-1:0] remaining,
    output logic             active,
    output logic             warning,
    output logic             timeout,
`ifdef SESSION_TIMER_BCD_EN
    output logic [3:0]       rem_tens,
    output logic [3:0]       rem_ones,
`endif
    output logic             expired
);
    typedef enum logic [1:0] {IDLE, RUN, WARN, EXPIRED} state_t;

    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(TIMEOUT_SEC);
    localparam logic [CNT_W-1:0] WARN_V  = CNT_W'(WARN_SEC);
    localparam bit               ILLEGAL = TIMEOUT_SEC <= WARN_SEC;

    state_t           state, state_n;
    logic             s1, s2, tick, live, reload, dec, to_n;
    logic [CNT_W-1:0] rem_n, rem_dec;

    always_comb begin
        tick    = s1 & ~s2;
        live    = (state == RUN) || (state == WARN);
        rem_dec = remaining - CNT_W'(1);
        state_n = state;
        rem_n   = remaining;
        to_n    = 1'b0;
        reload  = 1'b0;
        dec     = 1'b0;
        if (stop) begin
            state_n = IDLE;
            rem_n   = '0;
        end else if (start) begin
            reload  = 1'b1;
            rem_n   = RELOAD;
            // an illegal TIMEOUT_SEC <= WARN_SEC opens straight into the warning window
            state_n = (state == IDLE && ILLEGAL) ? WARN : RUN;
        end else if (kick && live) begin
            reload  = 1'b1;
            rem_n   = RELOAD;
            state_n = RUN;
        end else if (tick && live && remaining != '0) begin
            dec   = 1'b1;
            rem_n = rem_dec;
            if (rem_dec == '0) begin
                state_n = EXPIRED;
                to_n    = 1'b1;
            end else if (rem_dec <= WARN_V) begin
                state_n = WARN;
            end
        end
    end

    // flags are registered from the next state so they move on the same edge as it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= IDLE;
            remaining <= '0;
            active    <= 1'b0;
            warning   <= 1'b0;
            timeout   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            s1        <= sec_in;
            s2        <= s1;
            state     <= state_n;
            remaining <= rem_n;
            active    <= (state_n == RUN) || (state_n == WARN);
            warning   <= state_n == WARN;
            timeout   <= to_n;
            expired   <= state_n == EXPIRED;
        end
    end

`ifdef SESSION_TIMER_BCD_EN
    localparam int         CLAMP = (TIMEOUT_SEC > 99) ? 99 : TIMEOUT_SEC;
    localparam logic [3:0] RT    = 4'(CLAMP / 10);
    localparam logic [3:0] RO    = 4'(CLAMP % 10);

    // parallel BCD counter; above 99 the display holds 99 until remaining drops below it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_tens <= 4'd0;
            rem_ones <= 4'd0;
        end else if (stop) begin
            rem_tens <= 4'd0;
            rem_ones <= 4'd0;
        end else if (reload) begin
            rem_tens <= RT;
            rem_ones <= RO;
        end else if (dec && 32'(remaining) <= 32'd99) begin
            rem_tens <= (rem_ones == 4'd0) ? rem_tens - 4'd1 : rem_tens;
            rem_ones <= (rem_ones == 4'd0) ? 4'd9 : rem_ones - 4'd1;
        end
    end
`endif
endmodule

// File: tb/tb_atm_session_timer.sv
// tb_atm_session_timer: directed self-checking bench for atm_session_timer (TIMEOUT_SEC=5, WARN_SEC=2).
module tb_atm_session_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_in = 1'b0;
    logic       start = 1'b0;
    logic       kick = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] remaining;
    logic       active, warning, timeout, expired;
`ifdef SESSION_TIMER_BCD_EN
    logic [3:0] rem_tens, rem_ones;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    atm_session_timer #(.TIMEOUT_SEC(5), .WARN_SEC(2), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .sec_in(sec_in),
        .start(start),
        .kick(kick),
        .stop(stop),
        .remaining(remaining),
        .active(active),
        .warning(warning),
        .timeout(timeout),
`ifdef SESSION_TIMER_BCD_EN
        .rem_tens(rem_tens),
        .rem_ones(rem_ones),
`endif
        .expired(expired)
    );

    always #5 clk = ~clk;

    // raise sec_in; returns at the negedge after the tick has been applied
    task automatic sec_rise;
        sec_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // finish the 20-cycle square-wave period started by sec_rise
    task automatic sec_fall;
        repeat (8) @(negedge clk);
        sec_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic one_sec;
        sec_rise();
        sec_fall();
    endtask

    task automatic p_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic p_kick;
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
    endtask

    task automatic p_stop;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sec_in = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({remaining, active, warning, timeout, expired} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_during got rem=%0d a=%b w=%b t=%b e=%b want all 0", remaining, active, warning, timeout, expired);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({remaining, active, warning, timeout, expired} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_release got rem=%0d a=%b w=%b t=%b e=%b want all 0", remaining, active, warning, timeout, expired);
        end
        sec_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_countdown;
        logic [7:0] exp_rem [4] = '{8'd4, 8'd3, 8'd2, 8'd1};
        logic       exp_w   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        p_start();
        n_cmp++;
        if (remaining !== 8'd5 || active !== 1'b1 || warning !== 1'b0) begin
            n_bad++;
            $display("FAIL cd_start got rem=%0d a=%b w=%b want 5 1 0", remaining, active, warning);
        end
`ifdef SESSION_TIMER_BCD_EN
        n_cmp++;
        if (rem_tens !== 4'd0 || rem_ones !== 4'd5) begin
            n_bad++;
            $display("FAIL bcd_start got %0d%0d want 05", rem_tens, rem_ones);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            one_sec();
            n_cmp++;
            if (remaining !== exp_rem[i] || warning !== exp_w[i] || active !== 1'b1 || timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL cd_step%0d got rem=%0d w=%b a=%b t=%b want %0d %b 1 0", i, remaining, warning, active, timeout, exp_rem[i], exp_w[i]);
            end
`ifdef SESSION_TIMER_BCD_EN
            if (i == 0) begin
                n_cmp++;
                if (rem_tens !== 4'd0 || rem_ones !== 4'd4) begin
                    n_bad++;
                    $display("FAIL bcd_tick got %0d%0d want 04", rem_tens, rem_ones);
                end
            end
`endif
        end
        sec_rise();
        n_cmp++;
        if (remaining !== 8'd0 || timeout !== 1'b1 || expired !== 1'b1 || active !== 1'b0 || warning !== 1'b0) begin
            n_bad++;
            $display("FAIL cd_expire got rem=%0d t=%b e=%b a=%b w=%b want 0 1 1 0 0", remaining, timeout, expired, active, warning);
        end
        @(negedge clk);
        n_cmp++;
        if (timeout !== 1'b0 || expired !== 1'b1) begin
            n_bad++;
            $display("FAIL cd_pulse_width got t=%b e=%b want 0 1", timeout, expired);
        end
        sec_fall();
        p_stop();
        n_cmp++;
        if ({remaining, active, warning, timeout, expired} !== 12'h0) begin
            n_bad++;
            $display("FAIL cd_stop got rem=%0d a=%b e=%b want 0 0 0", remaining, active, expired);
        end
    endtask

    task automatic test_kick_warn;
        p_start();
        repeat (4) one_sec();
        p_kick();
        n_cmp++;
        if (remaining !== 8'd5 || warning !== 1'b0 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL kick_warn got rem=%0d w=%b a=%b want 5 0 1", remaining, warning, active);
        end
        sec_rise();
        n_cmp++;
        if (remaining !== 8'd4 || timeout !== 1'b0 || expired !== 1'b0) begin
            n_bad++;
            $display("FAIL kick_resume got rem=%0d t=%b e=%b want 4 0 0", remaining, timeout, expired);
        end
        sec_fall();
        p_stop();
    endtask

    task automatic test_kick_tick;
        p_start();
        repeat (2) one_sec();
        sec_in = 1'b1;
        @(negedge clk);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        n_cmp++;
        if (remaining !== 8'd5) begin
            n_bad++;
            $display("FAIL kick_tick got rem=%0d want 5", remaining);
        end
        sec_fall();
        p_stop();
    endtask

    task automatic test_expired_kick;
        p_start();
        repeat (5) one_sec();
        p_kick();
        n_cmp++;
        if (expired !== 1'b1 || remaining !== 8'd0 || active !== 1'b0) begin
            n_bad++;
            $display("FAIL exp_kick got e=%b rem=%0d a=%b want 1 0 0", expired, remaining, active);
        end
        one_sec();
        n_cmp++;
        if (expired !== 1'b1 || remaining !== 8'd0) begin
            n_bad++;
            $display("FAIL exp_tick got e=%b rem=%0d want 1 0", expired, remaining);
        end
        p_start();
        n_cmp++;
        if (remaining !== 8'd5 || expired !== 1'b0 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL exp_start got rem=%0d e=%b a=%b want 5 0 1", remaining, expired, active);
        end
        p_stop();
    endtask

    task automatic test_stop_expiry;
        p_start();
        repeat (4) one_sec();
        sec_in = 1'b1;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({remaining, active, warning, timeout, expired} !== 12'h0) begin
                n_bad++;
                $display("FAIL stop_expiry%0d got rem=%0d a=%b t=%b e=%b want all 0", i, remaining, active, timeout, expired);
            end
            @(negedge clk);
        end
        sec_fall();
    endtask

    task automatic test_reset_mid;
        p_start();
        one_sec();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({remaining, active, warning, timeout, expired} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_mid got rem=%0d a=%b t=%b want 0 0 0", remaining, active, timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_countdown();
        test_kick_warn();
        test_kick_tick();
        test_expired_kick();
        test_stop_expiry();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
